ibex_obi_mem_model: RTL and testbench

IBEX_OBI_MEM_MODEL -- requirements
Module: ibex_obi_mem_model

---
 rtl/ibex_obi_mem_model.sv | 184 ++++++++++++++++++
 tb/tb_ibex_obi_mem_model.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_obi_mem_model.sv
// OBI memory model for Ibex-style instruction/data ports.
// Word-addressed byte-enabled RAM behind a configurable grant delay and a
// response FIFO whose entries age until the minimum response latency elapses.
// Fault-injection inputs can force an unsolicited grant or response, and each
// such event is counted.
module ibex_obi_mem_model #(
  parameter int AddrWidth      = 32,
  parameter int MemDepth       = 1024,
  parameter int MaxOutstanding = 2,
  parameter int GntLatency     = 0,
  parameter int RvalidLatency  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic [6:0]           rdata_intg_o,
  output logic                 err_o,
  input  logic                 inj_gnt_i,
  input  logic                 inj_rvalid_i,
  input  logic [31:0]          inj_rdata_i,
  output logic [7:0]           unsol_cnt_o
);

  localparam int IdxW  = $clog2(MemDepth);
  localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW  = $clog2(MaxOutstanding + 1);
  localparam int AgeW  = $clog2(RvalidLatency + 1);
  localparam int WaitW = (GntLatency > 0) ? $clog2(GntLatency + 1) : 1;

  // Inverted SECDED(39,32) encoder: Hsiao check bits XOR 7'h2A so that an
  // all-zero word does not produce an all-zero codeword.
  function automatic logic [6:0] secded_inv_enc(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606BD25);
    c[1] = ^(d & 32'hDEBA8050);
    c[2] = ^(d & 32'h413D89AA);
    c[3] = ^(d & 32'h31234ED1);
    c[4] = ^(d & 32'hC2C1323B);
    c[5] = ^(d & 32'h2DCC624C);
    c[6] = ^(d & 32'h98505586);
    return c ^ 7'h2A;
  endfunction

  logic [31:0]     mem_q       [MemDepth];
  logic [31:0]     fifo_data_q [MaxOutstanding];
  logic            fifo_err_q  [MaxOutstanding];
  logic [AgeW-1:0] fifo_age_q  [MaxOutstanding];
  logic [AgeW-1:0] fifo_age_d  [MaxOutstanding];

  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [7:0]       unsol_q, unsol_d;
  logic [8:0]       unsol_sum;

  logic [IdxW-1:0] word_idx;
  logic            addr_err, head_due, fifo_room, wait_ok, accept;
  logic            inj_gnt_evt, inj_rvalid_evt;
  logic [31:0]     push_data;

  // Byte-offset bits never select anything in a word-organised memory.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

  // Request decode, grant decision and fault-injection qualification.
  always_comb begin
    word_idx       = addr_i[IdxW+1:2];
    addr_err       = |(addr_i >> (IdxW + 2));
    head_due       = (count_q != '0) && (fifo_age_q[head_q] >= AgeW'(RvalidLatency));
    // A pop in this cycle frees a slot, so a full FIFO can still accept.
    fifo_room      = (count_q != CntW'(MaxOutstanding)) || head_due;
    wait_ok        = (GntLatency == 0) || (wait_q >= WaitW'(GntLatency));
    accept         = rst_ni && req_i && wait_ok && fifo_room;
    inj_gnt_evt    = rst_ni && inj_gnt_i && !req_i;
    inj_rvalid_evt = rst_ni && inj_rvalid_i && !head_due;
    push_data      = (we_i || addr_err) ? 32'h0 : mem_q[word_idx];
  end

  // Response port: real responses win over injected ones; idle outputs are zero.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    gnt_o    = accept || inj_gnt_evt;
    rvalid_o = head_due || inj_rvalid_evt;
    rdata_o  = 32'h0;
    err_o    = 1'b0;
    if (head_due) begin
      rdata_o = fifo_data_q[head_q];
      err_o   = fifo_err_q[head_q];
    end else if (inj_rvalid_evt) begin
      rdata_o = inj_rdata_i;
    end
  end

  assign rdata_intg_o = secded_inv_enc(rdata_o);
  assign unsol_cnt_o  = unsol_q;

  // Next-state for FIFO pointers, occupancy, entry ages, wait and event counters.
  always_comb begin
    // NOTE: combinational next-state uses blocking '=' so later statements see
    // earlier updates within the same evaluation; flops below use '<=' only.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (head_due) begin
      head_d = (head_q == PtrW'(MaxOutstanding - 1)) ? '0 : head_q + 1'b1;
    end
    if (accept) begin
      tail_d = (tail_q == PtrW'(MaxOutstanding - 1)) ? '0 : tail_q + 1'b1;
    end
    case ({accept, head_due})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Ages saturate at the latency; a fresh entry counts the grant edge as one.
    for (int i = 0; i < MaxOutstanding; i++) begin
      fifo_age_d[i] = (fifo_age_q[i] >= AgeW'(RvalidLatency)) ? fifo_age_q[i]
                                                              : fifo_age_q[i] + 1'b1;
    end
    if (accept) begin
      fifo_age_d[tail_q] = AgeW'(1);
    end

    // Wait counter stops once the grant delay is met; a full FIFO just holds it.
    if (!req_i || accept) begin
      wait_d = '0;
    end else if (!wait_ok) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end

    unsol_sum = {1'b0, unsol_q} + {8'h0, inj_gnt_evt} + {8'h0, inj_rvalid_evt};
    unsol_d   = unsol_sum[8] ? 8'hFF : unsol_sum[7:0];
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wait_q  <= '0;
      unsol_q <= '0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_age_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      unsol_q <= unsol_d;
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_age_q[i] <= fifo_age_d[i];
      end
    end
  end

  // Storage: memory byte writes and FIFO payload capture at acceptance.
  // NOTE: storage arrays are deliberately not reset; memory contents survive
  // reset and FIFO payload is only observed through the reset-cleared count.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_data_q[tail_q] <= push_data;
      fifo_err_q[tail_q]  <= addr_err;
      if (we_i && !addr_err) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_obi_mem_model.sv
// Scoreboard bench for ibex_obi_mem_model: three instances with different
// latency/depth settings are driven by randomized and directed transactions.
// A cycle-level reference model predicts grant cycles and response cycles.
module tb_ibex_obi_mem_model;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [N];
  logic        we [N];
  logic [3:0]  be [N];
  logic [31:0] addr [N];
  logic [31:0] wdata [N];
  logic        inj_gnt [N];
  logic        inj_rvalid [N];
  logic [31:0] inj_rdata [N];
  logic        gnt [N];
  logic        rvalid [N];
  logic [31:0] rdata [N];
  logic [6:0]  intg [N];
  logic        err [N];
  logic [7:0]  unsol [N];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ibex_obi_mem_model u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .rdata_intg_o(intg[0]), .err_o(err[0]),
    .inj_gnt_i(inj_gnt[0]), .inj_rvalid_i(inj_rvalid[0]), .inj_rdata_i(inj_rdata[0]),
    .unsol_cnt_o(unsol[0])
  );

  ibex_obi_mem_model #(.GntLatency(2), .RvalidLatency(3), .MaxOutstanding(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .rdata_intg_o(intg[1]), .err_o(err[1]),
    .inj_gnt_i(inj_gnt[1]), .inj_rvalid_i(inj_rvalid[1]), .inj_rdata_i(inj_rdata[1]),
    .unsol_cnt_o(unsol[1])
  );

  ibex_obi_mem_model #(.GntLatency(0), .RvalidLatency(4), .MaxOutstanding(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .rdata_intg_o(intg[2]), .err_o(err[2]),
    .inj_gnt_i(inj_gnt[2]), .inj_rvalid_i(inj_rvalid[2]), .inj_rdata_i(inj_rdata[2]),
    .unsol_cnt_o(unsol[2])
  );

  function automatic int gl(input int d);
    case (d)
      1:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int rl(input int d);
    case (d)
      1:       return 3;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int mo(input int d);
    return 2;
  endfunction

  // Reference integrity: parity of data bits selected by each check-bit mask.
  function automatic logic [6:0] intg_ref(input logic [31:0] data);
    logic [31:0] msk;
    logic [6:0]  c;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       msk = 32'h2606BD25;
        1:       msk = 32'hDEBA8050;
        2:       msk = 32'h413D89AA;
        3:       msk = 32'h31234ED1;
        4:       msk = 32'hC2C1323B;
        5:       msk = 32'h2DCC624C;
        default: msk = 32'h98505586;
      endcase
      c[i] = 1'b0;
      for (int b = 0; b < 32; b++) if (msk[b]) c[i] = c[i] ^ data[b];
    end
    return c ^ 7'b0101010;
  endfunction

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q [N][$];
  int          out_q [N][$];
  int          last_rsp [N];
  int          unsol_m [N];
  logic [31:0] mem_m [N][1024];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int d, input logic [63:0] got,
                       input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %0h want %0h", name, d, cyc, got, want);
    end
  endtask

  task automatic push_exp(input int d, input int c, input logic [31:0] data, input logic e);
    exp_t x;
    x.cyc  = c;
    x.data = data;
    x.err  = e;
    exp_q[d].push_back(x);
  endtask

  // Monitor: every response is popped from the scoreboard and compared.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < N; d++) begin
      if (rvalid[d] === 1'b1) begin
        if (exp_q[d].size() == 0) begin
          check("rvalid_unexpected", d, 64'(rvalid[d]), 64'd0);
        end else begin
          e = exp_q[d].pop_front();
          check("rsp_cycle", d, 64'(cyc), 64'(e.cyc));
          check("rsp_rdata", d, 64'(rdata[d]), 64'(e.data));
          check("rsp_err", d, 64'(err[d]), 64'(e.err));
          check("rsp_intg", d, 64'(intg[d]), 64'(intg_ref(e.data)));
        end
      end else begin
        check("idle_zero", d, {31'b0, err[d], rdata[d]}, 64'd0);
        if (exp_q[d].size() > 0 && exp_q[d][0].cyc <= cyc) begin
          check("rvalid_missing", d, 64'(rvalid[d]), 64'd1);
          void'(exp_q[d].pop_front());
        end
      end
    end
  end

  // One OBI transaction: hold the request until the model says it is granted,
  // checking gnt_o every cycle, then record the predicted response.
  task automatic do_txn(input int d, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] wd, input logic hold_inj);
    int          waited = 0;
    int          t, rsp, idx;
    bit          done = 0;
    logic        exp_g, e;
    logic [31:0] data;
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd; inj_gnt[d] = hold_inj;
    while (!done) begin
      @(negedge clk);
      t = cyc;
      while (out_q[d].size() > 0 && out_q[d][0] <= t) void'(out_q[d].pop_front());
      exp_g = (waited >= gl(d)) && (out_q[d].size() < mo(d));
      check("gnt", d, 64'(gnt[d]), 64'(exp_g));
      if (exp_g) begin
        rsp = t + rl(d);
        if (rsp <= last_rsp[d]) rsp = last_rsp[d] + 1;
        last_rsp[d] = rsp;
        out_q[d].push_back(rsp);
        e   = (a >> 12) != 0;
        idx = int'(a[11:2]);
        data = 32'h0;
        if (w) begin
          if (!e) for (int k = 0; k < 4; k++) if (b[k]) mem_m[d][idx][8*k +: 8] = wd[8*k +: 8];
        end else if (!e) begin
          data = mem_m[d][idx];
        end
        push_exp(d, rsp, data, e);
        done = 1;
      end else begin
        waited++;
        if (waited > 64) begin
          check("gnt_timeout", d, 64'(waited), 64'd64);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    req[d] = 1'b0;
    inj_gnt[d] = 1'b0;
  endtask

  task automatic prefill(input int d);
    for (int w = 0; w < 16; w++) do_txn(d, 1'b1, 4'hF, 32'(w * 4), $urandom, 1'b0);
  endtask

  task automatic run_random(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      int          k;
      logic [31:0] a;
      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(12, 31));
      do_txn(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, 1'b0);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      repeat (k) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain(input int d);
    int k = 0;
    while (exp_q[d].size() > 0 && k < 64) begin
      @(posedge clk);
      k++;
    end
    check("drain_empty", d, 64'(exp_q[d].size()), 64'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b0;
    for (int d = 0; d < N; d++) begin
      req[d] = 0; we[d] = 0; be[d] = 0; addr[d] = 0; wdata[d] = 0;
      inj_gnt[d] = 0; inj_rvalid[d] = 0; inj_rdata[d] = 0;
      last_rsp[d] = 0; unsol_m[d] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check("reset_gnt", d, 64'(gnt[d]), 64'd0);
      check("reset_rvalid", d, 64'(rvalid[d]), 64'd0);
      check("reset_unsol", d, 64'(unsol[d]), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    fork
      prefill(0);
      prefill(1);
      prefill(2);
    join

    // Full-word write, read-back, byte-lane merge and out-of-range read.
    do_txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    do_txn(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    do_txn(0, 1'b1, 4'h1, 32'h10, 32'h000000AA, 1'b0);
    do_txn(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    do_txn(0, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b0);
    // Delayed grant with long response latency.
    do_txn(1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    // Three back-to-back reads into a two-deep FIFO.
    do_txn(2, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
    do_txn(2, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
    do_txn(2, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0);

    fork
      run_random(0, 150);
      run_random(1, 150);
      run_random(2, 150);
    join
    for (int d = 0; d < N; d++) drain(d);
    #1;

    // Unsolicited grant, then unsolicited response with an empty FIFO.
    inj_gnt[0] = 1'b1;
    @(negedge clk);
    check("inj_gnt_pulse", 0, 64'(gnt[0]), 64'd1);
    unsol_m[0]++;
    @(posedge clk);
    #1 inj_gnt[0] = 1'b0;
    inj_rvalid[0] = 1'b1;
    inj_rdata[0] = 32'hFFFFFFFF;
    push_exp(0, cyc, 32'hFFFFFFFF, 1'b0);
    unsol_m[0]++;
    @(posedge clk);
    #1 inj_rvalid[0] = 1'b0;
    @(negedge clk);
    check("inj_no_gnt", 0, 64'(gnt[0]), 64'd0);
    check("unsol_cnt", 0, 64'(unsol[0]), 64'(unsol_m[0]));

    // Injected response while a real one is due is ignored.
    @(posedge clk);
    #1;
    do_txn(0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
    inj_rvalid[0] = 1'b1;
    inj_rdata[0] = 32'h12345678;
    @(posedge clk);
    #1 inj_rvalid[0] = 1'b0;
    @(negedge clk);
    check("unsol_ignored_rvalid", 0, 64'(unsol[0]), 64'(unsol_m[0]));

    // Injected grant while a real request is pending is ignored.
    @(posedge clk);
    #1;
    do_txn(1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b1);
    drain(1);
    @(negedge clk);
    check("unsol_ignored_gnt", 1, 64'(unsol[1]), 64'(unsol_m[1]));

    // Both injections in one cycle count twice.
    @(posedge clk);
    #1;
    inj_gnt[1] = 1'b1;
    inj_rvalid[1] = 1'b1;
    inj_rdata[1] = 32'h5A5AC3C3;
    push_exp(1, cyc, 32'h5A5AC3C3, 1'b0);
    unsol_m[1] += 2;
    @(negedge clk);
    check("inj_both_gnt", 1, 64'(gnt[1]), 64'd1);
    @(posedge clk);
    #1 inj_gnt[1] = 1'b0;
    inj_rvalid[1] = 1'b0;
    @(negedge clk);
    check("unsol_double", 1, 64'(unsol[1]), 64'(unsol_m[1]));

    // Saturation of the unsolicited-event counter.
    @(posedge clk);
    #1 inj_gnt[0] = 1'b1;
    repeat (260) @(posedge clk);
    #1 inj_gnt[0] = 1'b0;
    unsol_m[0] = (unsol_m[0] + 260 > 255) ? 255 : unsol_m[0] + 260;
    @(negedge clk);
    check("unsol_saturate", 0, 64'(unsol[0]), 64'(unsol_m[0]));

    // Reset in the middle of an outstanding read discards its response.
    @(posedge clk);
    #1;
    do_txn(2, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
    #1 rst_n = 1'b0;
    for (int d = 0; d < N; d++) begin
      exp_q[d].delete();
      out_q[d].delete();
      last_rsp[d] = 0;
      unsol_m[d] = 0;
    end
    req[0] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check("midreset_gnt", d, 64'(gnt[d]), 64'd0);
      check("midreset_unsol", d, 64'(unsol[d]), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    req[0] = 1'b0;
    // First-cycle grant after reset; memory contents are retained.
    do_txn(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    repeat (8) @(posedge clk);
    for (int d = 0; d < N; d++) drain(d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
